// File: rtl/lcd_ctrl.sv
// lcd_ctrl: HD44780-style character LCD write sequencer behind the LSU LCD register.
// Latency: accepted write -> SETUP next cycle; EN after T_SETUP_CYC; busy clears after setup+EN+hold+exec.
// Backpressure: none; one command buffered while busy, further commands dropped with sticky ovf.
//
// Ports:
//   clk_i, rst_i          single clock, synchronous active-high reset
//   wr_en_i, wr_data_i    store strobe and payload
//                         (bit31 ON, bit30 CLR_OVF, bit9 RS, bits7:0 DATA)
//   busy_o, status_o      load-side status
//                         (bit31 busy, bit30 ovf, bit29 pending, bit8 on, bits7:0 last DATA)
//   lcd_on_o, lcd_en_o, lcd_rs_o, lcd_rw_o, lcd_data_o   panel pins
//
// Optional feature: define LCD_INIT_EN to add a power-up wait and an automatic
// init sequence (0x38, 0x0C, 0x01, 0x06) before user commands run.

module lcd_ctrl #(
    parameter int unsigned T_SETUP_CYC = 2,
    parameter int unsigned T_EN_CYC    = 12,
    parameter int unsigned T_HOLD_CYC  = 2,
    parameter int unsigned T_EXEC_CYC  = 2000,
    parameter int unsigned T_CLR_CYC   = 82000,
    parameter int unsigned T_PWRUP_CYC = 750000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wr_en_i,
    input  logic [31:0] wr_data_i,
    output logic        busy_o,
    output logic [31:0] status_o,
    output logic        lcd_on_o,
    output logic        lcd_en_o,
    output logic        lcd_rs_o,
    output logic        lcd_rw_o,
    output logic [7:0]  lcd_data_o
);

    // Shared down-counter sized for the longest wait.
    localparam int unsigned MAX_A = (T_SETUP_CYC > T_EN_CYC)   ? T_SETUP_CYC : T_EN_CYC;
    localparam int unsigned MAX_B = (T_HOLD_CYC  > T_EXEC_CYC) ? T_HOLD_CYC  : T_EXEC_CYC;
    localparam int unsigned MAX_C = (T_CLR_CYC   > T_PWRUP_CYC) ? T_CLR_CYC  : T_PWRUP_CYC;
    localparam int unsigned MAX_D = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned MAXP  = (MAX_C > MAX_D) ? MAX_C : MAX_D;
    localparam int unsigned CW    = $clog2(MAXP) + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_PULSE = 3'd2,
        S_HOLD  = 3'd3,
        S_EXEC  = 3'd4,
        S_PWRUP = 3'd5,
        S_INIT  = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            pend_q, pend_d;
    logic            pend_rs_q, pend_rs_d;
    logic            pend_on_q, pend_on_d;
    logic [7:0]      pend_data_q, pend_data_d;
    logic            ovf_q, ovf_d;
    logic            lcd_rs_q, lcd_rs_d;
    logic            lcd_on_q, lcd_on_d;
    logic [7:0]      lcd_data_q, lcd_data_d;

`ifdef LCD_INIT_EN
    logic            init_q, init_d;
    logic [1:0]      init_idx_q, init_idx_d;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h01;
            default: init_cmd = 8'h06;
        endcase
    endfunction
`endif

    // Payload bits that carry no meaning for this block.
    logic unused_wr_bits;
    assign unused_wr_bits = ^{wr_data_i[29:10], wr_data_i[8]};

    logic cmd_wr;      // a real command (not an ovf-clear)
    logic clr_wr;
    logic cnt_done;
    logic exec_long;   // command currently on the bus is clear/home
    logic wr_taken;    // write consumed by the FSM this cycle (started directly or refilled pending)

    assign cmd_wr    = wr_en_i & ~wr_data_i[30];
    assign clr_wr    = wr_en_i &  wr_data_i[30];
    assign cnt_done  = (cnt_q == '0);
    assign exec_long = ~lcd_rs_q & (lcd_data_q[7:2] == 6'd0) & (lcd_data_q[1:0] != 2'd0);

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        pend_rs_d   = pend_rs_q;
        pend_on_d   = pend_on_q;
        pend_data_d = pend_data_q;
        ovf_d       = ovf_q;
        lcd_rs_d    = lcd_rs_q;
        lcd_on_d    = lcd_on_q;
        lcd_data_d  = lcd_data_q;
        wr_taken    = 1'b0;
`ifdef LCD_INIT_EN
        init_d      = init_q;
        init_idx_d  = init_idx_q;
`endif

        if (clr_wr) begin
            ovf_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_wr) begin
                    state_d    = S_SETUP;
                    lcd_rs_d   = wr_data_i[9];
                    lcd_on_d   = wr_data_i[31];
                    lcd_data_d = wr_data_i[7:0];
                    wr_taken   = 1'b1;
                end
            end
            S_SETUP: if (cnt_done) state_d = S_PULSE;
            S_PULSE: if (cnt_done) state_d = S_HOLD;
            S_HOLD:  if (cnt_done) state_d = S_EXEC;
            S_EXEC: begin
                if (cnt_done) begin
`ifdef LCD_INIT_EN
                    if (init_q && (init_idx_q != 2'd3)) begin
                        init_idx_d = init_idx_q + 2'd1;
                        state_d    = S_INIT;
                    end else begin
                        init_d = 1'b0;
`endif
                        if (pend_q) begin
                            // Launch the buffered command; a write in this
                            // same cycle takes its slot in the buffer.
                            state_d     = S_SETUP;
                            lcd_rs_d    = pend_rs_q;
                            lcd_on_d    = pend_on_q;
                            lcd_data_d  = pend_data_q;
                            pend_d      = cmd_wr;
                            pend_rs_d   = wr_data_i[9];
                            pend_on_d   = wr_data_i[31];
                            pend_data_d = wr_data_i[7:0];
                            wr_taken    = 1'b1;
                        end else if (cmd_wr) begin
                            // Back-to-back start without an IDLE cycle.
                            state_d    = S_SETUP;
                            lcd_rs_d   = wr_data_i[9];
                            lcd_on_d   = wr_data_i[31];
                            lcd_data_d = wr_data_i[7:0];
                            wr_taken   = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
`ifdef LCD_INIT_EN
                    end
`endif
                end
            end
`ifdef LCD_INIT_EN
            S_PWRUP: if (cnt_done) state_d = S_INIT;
            S_INIT: begin
                state_d    = S_SETUP;
                lcd_rs_d   = 1'b0;
                lcd_on_d   = 1'b1;
                lcd_data_d = init_cmd(init_idx_q);
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Any command not consumed above lands in the buffer or overflows.
        if (cmd_wr && !wr_taken) begin
            if (!pend_q) begin
                pend_d      = 1'b1;
                pend_rs_d   = wr_data_i[9];
                pend_on_d   = wr_data_i[31];
                pend_data_d = wr_data_i[7:0];
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    // Counter reloads with (duration - 1) on each state entry so that every
    // state lasts exactly its programmed number of cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            case (state_d)
                S_SETUP: cnt_d = CW'(T_SETUP_CYC - 1);
                S_PULSE: cnt_d = CW'(T_EN_CYC - 1);
                S_HOLD:  cnt_d = CW'(T_HOLD_CYC - 1);
                S_EXEC:  cnt_d = exec_long ? CW'(T_CLR_CYC - 1) : CW'(T_EXEC_CYC - 1);
                S_PWRUP: cnt_d = CW'(T_PWRUP_CYC - 1);
                default: cnt_d = '0;
            endcase
        end else if (!cnt_done) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q      <= 1'b0;
            pend_rs_q   <= 1'b0;
            pend_on_q   <= 1'b0;
            pend_data_q <= 8'h00;
            ovf_q       <= 1'b0;
            lcd_rs_q    <= 1'b0;
            lcd_data_q  <= 8'h00;
`ifdef LCD_INIT_EN
            state_q     <= S_PWRUP;
            cnt_q       <= CW'(T_PWRUP_CYC - 1);
            lcd_on_q    <= 1'b1;
            init_q      <= 1'b1;
            init_idx_q  <= 2'd0;
`else
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            lcd_on_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pend_rs_q   <= pend_rs_d;
            pend_on_q   <= pend_on_d;
            pend_data_q <= pend_data_d;
            ovf_q       <= ovf_d;
            lcd_rs_q    <= lcd_rs_d;
            lcd_on_q    <= lcd_on_d;
            lcd_data_q  <= lcd_data_d;
`ifdef LCD_INIT_EN
            init_q      <= init_d;
            init_idx_q  <= init_idx_d;
`endif
        end
    end

    // All outputs are decoded from registers only; nothing combinational
    // from wr_en_i reaches a port.
    assign busy_o     = (state_q != S_IDLE) | pend_q;
    assign status_o   = {busy_o, ovf_q, pend_q, 20'd0, lcd_on_q, lcd_data_q};
    assign lcd_on_o   = lcd_on_q;
    assign lcd_en_o   = (state_q == S_PULSE);
    assign lcd_rs_o   = lcd_rs_q;
    assign lcd_rw_o   = 1'b0;
    assign lcd_data_o = lcd_data_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: directed bench for lcd_ctrl with short timing parameters.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_lcd_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        wr_en_i = 1'b0;
    logic [31:0] wr_data_i = 32'h0;
    logic        busy_o;
    logic [31:0] status_o;
    logic        lcd_on_o, lcd_en_o, lcd_rs_o, lcd_rw_o;
    logic [7:0]  lcd_data_o;

    int n_checks = 0;
    int n_fail   = 0;

    lcd_ctrl #(
        .T_SETUP_CYC(2), .T_EN_CYC(4), .T_HOLD_CYC(2),
        .T_EXEC_CYC(10), .T_CLR_CYC(40), .T_PWRUP_CYC(20)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .wr_en_i(wr_en_i), .wr_data_i(wr_data_i),
        .busy_o(busy_o), .status_o(status_o), .lcd_on_o(lcd_on_o),
        .lcd_en_o(lcd_en_o), .lcd_rs_o(lcd_rs_o), .lcd_rw_o(lcd_rw_o),
        .lcd_data_o(lcd_data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [31:0] d);
        wr_en_i   = 1'b1;
        wr_data_i = d;
        tick();
        wr_en_i   = 1'b0;
        wr_data_i = 32'h0;
    endtask

    task automatic wait_to(inout int rel, input int target);
        while (rel < target) begin
            tick();
            rel++;
        end
    endtask

    // Called on the cycle after acceptance (index 1); returns the index at
    // which EN first rose, first fell, and busy dropped (-1 if never).
    task automatic measure(input int limit, output int rise, output int fall, output int bfall);
        rise = -1; fall = -1; bfall = -1;
        for (int i = 1; i <= limit; i++) begin
            if (i > 1) tick();
            if (lcd_en_o && rise < 0) rise = i;
            if (!lcd_en_o && rise >= 0 && fall < 0) fall = i;
            if (!busy_o) begin
                bfall = i;
                break;
            end
        end
    endtask

    task automatic single_write(input string tag);
        int r, f, b;
        issue(32'h8000_0241);
        chk({tag, "_rs"},   {31'd0, lcd_rs_o}, 32'd1);
        chk({tag, "_data"}, {24'd0, lcd_data_o}, 32'h41);
        chk({tag, "_on"},   {31'd0, lcd_on_o}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy_o}, 32'd1);
        chk({tag, "_stat"}, status_o, 32'h8000_0141);
        measure(100, r, f, b);
        chk({tag, "_en_rise"}, r, 3);
        chk({tag, "_en_fall"}, f, 7);
        chk({tag, "_busy_fall"}, b, 19);
        chk({tag, "_stat_end"}, status_o, 32'h0000_0141);
    endtask

    initial begin
        int rel, r, f, b;
        int en_seen;
        rst_i = 1'b1;
        tick(); tick();
        rst_i = 1'b0;

`ifdef LCD_INIT_EN
        begin
            logic [7:0] seen [4];
            int npulse, first_rise;
            logic prev_en, busy_gap;
            chk("init_rst_busy", {31'd0, busy_o}, 32'd1);
            chk("init_rst_on",   {31'd0, lcd_on_o}, 32'd1);
            npulse = 0; first_rise = -1; prev_en = 1'b0; busy_gap = 1'b0; b = -1;
            for (int i = 0; i < 1000; i++) begin
                if (i > 0) tick();
                if (lcd_en_o && !prev_en) begin
                    if (npulse < 4) seen[npulse] = lcd_data_o;
                    if (first_rise < 0) first_rise = i;
                    npulse++;
                end
                prev_en = lcd_en_o;
                if (!busy_o) begin
                    if (npulse < 4) busy_gap = 1'b1;
                    b = i;
                    break;
                end
            end
            chk("init_pwrup_wait", {31'd0, first_rise >= 20}, 32'd1);
            chk("init_npulse", npulse, 4);
            chk("init_cmd0", {24'd0, seen[0]}, 32'h38);
            chk("init_cmd1", {24'd0, seen[1]}, 32'h0C);
            chk("init_cmd2", {24'd0, seen[2]}, 32'h01);
            chk("init_cmd3", {24'd0, seen[3]}, 32'h06);
            chk("init_busy_held", {31'd0, busy_gap}, 32'd0);
            chk("init_busy_falls", {31'd0, b > 0}, 32'd1);
            tick();
            single_write("init_after");
        end
`else
        // Reset state
        chk("rst_status", status_o, 32'h0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_en", {31'd0, lcd_en_o}, 32'd0);
        chk("rst_on", {31'd0, lcd_on_o}, 32'd0);
        chk("rst_rw", {31'd0, lcd_rw_o}, 32'd0);
        tick();

        // Single data write
        single_write("t1");
        tick();

        // Clear command uses the long execution wait
        issue(32'h8000_0001);
        chk("clr_rs", {31'd0, lcd_rs_o}, 32'd0);
        chk("clr_data", {24'd0, lcd_data_o}, 32'h01);
        measure(200, r, f, b);
        chk("clr_en_rise", r, 3);
        chk("clr_busy_fall", b, 49);
        tick();

        // Three back-to-back writes: run, queue, drop
        issue(32'h8000_0241); rel = 1;
        issue(32'h8000_0242); rel = 2;
        chk("q_pend", {31'd0, status_o[29]}, 32'd1);
        chk("q_ovf0", {31'd0, status_o[30]}, 32'd0);
        issue(32'h8000_0243); rel = 3;
        chk("q_ovf1", {31'd0, status_o[30]}, 32'd1);
        chk("q_pend_kept", {31'd0, status_o[29]}, 32'd1);
        wait_to(rel, 18);
        chk("q_first_last", {24'd0, lcd_data_o}, 32'h41);
        tick(); rel++;
        chk("q_second_start", {24'd0, lcd_data_o}, 32'h42);
        chk("q_pend_empty", {31'd0, status_o[29]}, 32'd0);
        measure(100, r, f, b);
        chk("q_second_rise", r, 3);
        chk("q_second_bfall", b, 19);
        chk("q_third_dropped", status_o, 32'h4000_0142);
        issue(32'h4000_0000);
        chk("q_ovf_cleared", status_o, 32'h0000_0142);
        en_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (lcd_en_o || busy_o) en_seen++;
            tick();
        end
        chk("q_clr_no_pulse", en_seen, 0);

        // Write on the last EXEC cycle with pending full
        issue(32'h8000_0241); rel = 1;
        issue(32'h8000_0242); rel = 2;
        wait_to(rel, 18);
        wr_en_i = 1'b1; wr_data_i = 32'h8000_0244;
        tick(); rel++;
        wr_en_i = 1'b0; wr_data_i = 32'h0;
        chk("lx_launch", {24'd0, lcd_data_o}, 32'h42);
        chk("lx_refill", {31'd0, status_o[29]}, 32'd1);
        chk("lx_no_ovf", {31'd0, status_o[30]}, 32'd0);
        wait_to(rel, 36);
        chk("lx_b_last", {24'd0, lcd_data_o}, 32'h42);
        tick(); rel++;
        chk("lx_d_start", {24'd0, lcd_data_o}, 32'h44);
        measure(100, r, f, b);
        chk("lx_d_bfall", b, 19);
        chk("lx_end_stat", status_o, 32'h0000_0144);
        tick();

        // Write on the last EXEC cycle with pending empty: no IDLE gap
        issue(32'h8000_0241); rel = 1;
        wait_to(rel, 18);
        issue(32'h0000_0345); rel++;
        chk("ds_busy", {31'd0, busy_o}, 32'd1);
        chk("ds_data", {24'd0, lcd_data_o}, 32'h45);
        chk("ds_on", {31'd0, lcd_on_o}, 32'd0);
        measure(100, r, f, b);
        chk("ds_bfall", b, 19);
        tick();

        // Reset in the middle of an EN pulse with pending and ovf set
        issue(32'h8000_0241); rel = 1;
        issue(32'h8000_0242); rel = 2;
        issue(32'h8000_0243); rel = 3;
        tick(); rel++;
        chk("mr_in_pulse", {31'd0, lcd_en_o}, 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("mr_en", {31'd0, lcd_en_o}, 32'd0);
        chk("mr_status", status_o, 32'h0);
        chk("mr_pins", {22'd0, lcd_on_o, lcd_rs_o, lcd_data_o}, 32'h0);
        chk("mr_busy", {31'd0, busy_o}, 32'd0);
        tick();
        single_write("mr_after");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
